spi_slave_phy: RTL
==================

SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for sclk, cs_n and mosi (legal values 2..3).
REQ-002 Parameter IDLE_BYTE, default 8'h00, SHALL be the byte shifted out when no TX byte is pending.
REQ-003 Port clk, input, 1: system clock; the block has one clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port sclk, input, 1: raw SPI clock, asynchronous to clk.
REQ-006 Port cs_n, input, 1: raw chip select, active low, asynchronous to clk.
REQ-007 Port mosi, input, 1: raw master-out data.
REQ-008 Port miso, output, 1: slave-out data.
REQ-009 Port rx_data, output, 8: last received byte.
REQ-010 Port rx_valid / rx_ready, output / input, 1 each: RX stream handshake.
REQ-011 Port tx_data, input, 8; tx_valid / tx_ready, input / output, 1 each: TX stream handshake.
REQ-012 Port rx_overrun, output, 1: one-cycle pulse when a received byte is dropped.
REQ-013 Port busy, output, 1: high while the FSM is in ACTIVE.

Function
REQ-014 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, and support sclk frequencies up to clk/6.
REQ-015 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-016 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-017 IDLE->ACTIVE SHALL occur on a synchronized cs_n falling edge; ACTIVE->IDLE SHALL occur on a synchronized cs_n rising edge.
REQ-018 On entry to ACTIVE, the 3-bit bit counter SHALL clear to 0 and the TX shift register SHALL load the holding byte if one is pending, otherwise IDLE_BYTE.
REQ-019 In ACTIVE, each synchronized sclk rising edge SHALL shift synchronized mosi into the RX shift register LSB and increment the bit counter modulo 8.
REQ-020 On the rising edge that wraps the counter 7->0, the assembled byte SHALL be written to rx_data and rx_valid SHALL be set on the following clk edge, i.e. SYNC_STAGES+2 clk edges after the raw sclk edge was sampled.
REQ-021 rx_valid SHALL hold until a cycle with rx_ready=1, then clear; rx_data SHALL be stable while rx_valid=1.
REQ-022 If a byte completes while rx_valid=1 and rx_ready=0, the new byte SHALL be discarded, rx_data SHALL be unchanged, and rx_overrun SHALL pulse for one cycle.
REQ-023 If a byte completes in the same cycle that rx_valid&rx_ready holds, the new byte SHALL be accepted with no overrun.
REQ-024 A one-entry TX holding register SHALL accept tx_data when tx_valid&tx_ready; tx_ready SHALL equal "holding register empty".
REQ-025 In ACTIVE, on each synchronized sclk falling edge: if the bit counter is 0, the TX shift register SHALL reload (holding byte or IDLE_BYTE); otherwise it SHALL shift left by one.
REQ-026 A holding byte SHALL be consumed (register empty, tx_ready=1 next cycle) in the cycle it is loaded into the TX shift register.
REQ-027 If a load and a tx_valid&tx_ready acceptance occur in the same cycle, the accepted byte SHALL remain in the holding register for the next load.
REQ-028 miso SHALL equal TX shift register bit 7 in ACTIVE and 0 in IDLE.
REQ-029 A cs_n deassertion mid-byte SHALL discard the partial RX byte (no rx_valid) and the partially sent TX byte; the holding register SHALL be unaffected.
REQ-030 sclk edges while in IDLE SHALL be ignored.

Reset
REQ-031 While rst_n=0: FSM=IDLE, counter=0, shift registers=0, synchronizer flops cs_n=1 / sclk=0 / mosi=0, rx_data=0, rx_valid=0, rx_overrun=0, busy=0, miso=0, holding register empty (tx_ready=1).
REQ-032 Assertion of rst_n mid-transfer SHALL abort the transfer; after release the block SHALL wait in IDLE for the next cs_n falling edge.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum (IDLE, ACTIVE) and the BYTE_W=8 constant.
REQ-034 The synchronizer plus edge detector SHALL be one sub-module, spi_sync_edge, instantiated for sclk and cs_n; mosi SHALL use its synchronizer output only.

Verification
REQ-035 cs_n low, master sends 8'hA5 at clk/8 with rx_ready=1 -> exactly one rx_valid pulse with rx_data=8'hA5, no rx_overrun.
REQ-036 tx_data=8'h3C preloaded, then 2-byte transfer -> miso emits 8'h3C then IDLE_BYTE 8'h00 MSB first; tx_ready returns to 1 at cs_n fall.
REQ-037 rx_ready=0, master sends 8'h11 then 8'h22 -> rx_data stays 8'h11, one rx_overrun pulse at the second byte.
REQ-038 cs_n deasserted after 5 bits of 8'hFF, then full byte 8'h5A -> only one rx_valid with rx_data=8'h5A.
REQ-039 rst_n pulsed low after bit 3 of a byte -> all outputs at reset values; next full transfer of 8'hC3 received correctly.
REQ-040 rx_ready held at 1 while bytes 8'h01, 8'h02, 8'h03 are sent back-to-back -> three rx_valid pulses in order, no overrun.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave PHY.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(BYTE_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c =  sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY, MSB first, oversampled in the clk domain, with an
// RX valid/ready stream (overrun drop) and a one-entry TX holding register.
module spi_slave_phy
    import spi_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overrun,
    output logic              busy
);

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
    logic                   done_q, done_d;
    logic [BYTE_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic [BYTE_W-1:0]      hold_q, hold_d;
    logic                   hold_empty_q, hold_empty_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   load_c;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    // mosi only needs a level, aligned with the sclk synchronizer depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = 1'b0;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        load_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    load_c    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
                        bit_cnt_d  = CNT_W'(bit_cnt_q + CNT_W'(1));
                        done_d     = (bit_cnt_q == CNT_W'(BYTE_W - 1));
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == '0) begin
                            load_c = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading consumes a pending byte; acceptance only happens when empty
        if (load_c) begin
            tx_shift_d   = hold_empty_q ? IDLE_BYTE : hold_q;
            hold_empty_d = 1'b1;
        end
        if (tx_valid && hold_empty_q) begin
            hold_d       = tx_data;
            hold_empty_d = 1'b0;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    assign busy       = (state_q == ACTIVE);
    assign miso       = busy & tx_shift_q[BYTE_W-1];
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = overrun_q;
    assign tx_ready   = hold_empty_q;

endmodule
